// File: rtl/gpio_out_pkg.sv
// Shared definitions for gpio_out_port: register word map, response FSM state
// type and the byte-strobe to bit-mask helper.
package gpio_out_pkg;

  localparam logic [2:0] GPIO_DATA     = 3'd0;
  localparam logic [2:0] GPIO_SET      = 3'd1;
  localparam logic [2:0] GPIO_CLR      = 3'd2;
  localparam logic [2:0] GPIO_TOG      = 3'd3;
  localparam logic [2:0] GPIO_WDT_LOAD = 3'd4;
  localparam logic [2:0] GPIO_STATUS   = 3'd5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } gpio_state_e;

  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    logic [31:0] mask;
    mask = 32'h0000_0000;
    for (int b = 0; b < 4; b++) begin
      mask[b*8 +: 8] = strb[b] ? 8'hFF : 8'h00;
    end
    return mask;
  endfunction

endpackage

// File: rtl/gpio_out_wdt.sv
// Refresh watchdog for gpio_out_port: 32-bit down-counter that pulses expire on
// the cycle its count would fall from 1 to 0.
module gpio_out_wdt
  import gpio_out_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        reload,
  input  logic [31:0] load_value,
  output logic        expire
);

  logic [31:0] count;

  // Reload has priority over the decrement; the count rests at zero after expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 32'd0;
    end else if (reload) begin
      count <= load_value;
    end else if (count != 32'd0) begin
      count <= count - 32'd1;
    end else begin
      count <= count;
    end
  end

  assign expire = (count == 32'd1) && !reload && (load_value != 32'd0);

endmodule

// File: rtl/gpio_out_port.sv
// Memory-mapped 32-bit GPIO output register with set/clear/toggle aliases and a
// valid/ready request/response channel. Watchdog built when GPIO_OUT_WATCHDOG_EN is defined.
module gpio_out_port
  import gpio_out_pkg::*;
#(
  parameter logic [31:0] SAFE_VALUE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [4:0]  req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] data_out,
  output logic        wdt_tripped
);

  gpio_state_e state;
  logic [31:0] data_reg;
  logic [31:0] data_next;
  logic [31:0] rdata_now;
  logic [31:0] mask;
  logic [31:0] wmask;
  logic [31:0] wdt_load;
  logic [2:0]  idx;
  logic        accept;
  logic        wr;
  logic        refresh;
  logic        err_now;
  logic        expire;
  logic        tripped;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^req_addr[1:0];
  assign idx       = req_addr[4:2];
  assign accept    = (state == ST_IDLE) && req_valid;
  assign wr        = accept && req_we;
  assign mask      = strb_to_mask(req_wstrb);
  assign wmask     = req_wdata & mask;
  assign refresh   = wr && (idx <= GPIO_TOG);
  assign err_now   = (idx > GPIO_STATUS);
  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign data_out  = data_reg;

  // Next DATA value for the four aliases that modify it.
  always_comb begin
    data_next = data_reg;
    if (wr) begin
      case (idx)
        GPIO_DATA: data_next = (data_reg & ~mask) | wmask;
        GPIO_SET:  data_next = data_reg | wmask;
        GPIO_CLR:  data_next = data_reg & ~wmask;
        GPIO_TOG:  data_next = data_reg ^ wmask;
        default:   data_next = data_reg;
      endcase
    end else begin
      data_next = data_reg;
    end
  end

  // Read mux over pre-write register values; aliases and unmapped words read 0.
  always_comb begin
    rdata_now = 32'h0000_0000;
    case (idx)
      GPIO_DATA:     rdata_now = data_reg;
      GPIO_WDT_LOAD: rdata_now = wdt_load;
      GPIO_STATUS:   rdata_now = {31'h0000_0000, tripped};
      default:       rdata_now = 32'h0000_0000;
    endcase
  end

  // DATA register: a refresh write beats a simultaneous watchdog expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg <= SAFE_VALUE;
    end else if (refresh) begin
      data_reg <= data_next;
    end else if (expire) begin
      data_reg <= SAFE_VALUE;
    end else begin
      data_reg <= data_reg;
    end
  end

  // Request/response FSM with response fields captured at acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rsp_rdata <= 32'h0000_0000;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            state     <= ST_RESP;
            rsp_rdata <= req_we ? 32'h0000_0000 : rdata_now;
            rsp_err   <= err_now;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state <= ST_IDLE;
          end else begin
            state <= ST_RESP;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef GPIO_OUT_WATCHDOG_EN
  logic [31:0] load_reg;
  logic [31:0] load_next;
  logic        trip_reg;
  logic        wdt_reload;

  assign load_next  = (wr && (idx == GPIO_WDT_LOAD)) ? ((load_reg & ~mask) | wmask) : load_reg;
  assign wdt_reload = refresh || (wr && (idx == GPIO_WDT_LOAD));

  // WDT_LOAD register and trip flag; only a DATA-class write clears the flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_reg <= 32'h0000_0000;
      trip_reg <= 1'b0;
    end else begin
      load_reg <= load_next;
      if (refresh) begin
        trip_reg <= 1'b0;
      end else if (expire) begin
        trip_reg <= 1'b1;
      end else begin
        trip_reg <= trip_reg;
      end
    end
  end

  gpio_out_wdt u_wdt (
    .clk        (clk),
    .rst        (rst),
    .reload     (wdt_reload),
    .load_value (load_next),
    .expire     (expire)
  );

  assign wdt_load = load_reg;
  assign tripped  = trip_reg;
`else
  assign wdt_load = 32'h0000_0000;
  assign tripped  = 1'b0;
  assign expire   = 1'b0;
`endif

  assign wdt_tripped = tripped;

endmodule

// File: tb/tb_gpio_out_port.sv
// Self-checking bench for gpio_out_port: directed steps plus randomized traffic
// against a deadline-based behavioural model.
module tb_gpio_out_port;

  localparam logic [31:0] SAFE = 32'hA5A5_0F0F;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] data_out;
  logic        wdt_tripped;

  int     n_tests = 0;
  int     n_fail  = 0;
  longint edge_n  = 0;

  logic [31:0] m_data;
  logic [31:0] m_load;
  logic        m_trip;
  logic        m_armed;
  longint      m_deadline;

  gpio_out_port #(.SAFE_VALUE(SAFE)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .data_out(data_out), .wdt_tripped(wdt_tripped)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_data = SAFE; m_load = 32'h0; m_trip = 1'b0; m_armed = 1'b0; m_deadline = 0;
  endtask

  // The watchdog fires at the edge numbered refresh_edge + load.
  task automatic m_settle(input longint upto);
    if (m_armed && m_deadline <= upto) begin
      m_data = SAFE; m_trip = 1'b1; m_armed = 1'b0;
    end
  endtask

  task automatic m_arm(input longint e);
    if (m_load != 32'h0) begin
      m_armed = 1'b1; m_deadline = e + longint'(m_load);
    end else begin
      m_armed = 1'b0;
    end
  endtask

  task automatic m_apply(input logic we, input logic [4:0] addr, input logic [31:0] wd,
                         input logic [3:0] st, input longint e,
                         output logic [31:0] rd, output logic err);
    int w;
    logic [7:0] wb;
    w = int'(addr) / 4;
    m_settle(e - 1);
    err = (w >= 6);
    rd = 32'h0;
    if (!we) begin
      if (w == 0) rd = m_data;
`ifdef GPIO_OUT_WATCHDOG_EN
      if (w == 4) rd = m_load;
      if (w == 5) rd = {31'h0, m_trip};
`endif
    end else begin
      for (int b = 0; b < 4; b++) begin
        wb = wd[b*8 +: 8];
        if (st[b]) begin
          case (w)
            0: m_data[b*8 +: 8] = wb;
            1: m_data[b*8 +: 8] = m_data[b*8 +: 8] | wb;
            2: m_data[b*8 +: 8] = m_data[b*8 +: 8] & ~wb;
            3: m_data[b*8 +: 8] = m_data[b*8 +: 8] ^ wb;
`ifdef GPIO_OUT_WATCHDOG_EN
            4: m_load[b*8 +: 8] = wb;
`endif
            default: ;
          endcase
        end
      end
      if (w <= 3) begin
        m_trip = 1'b0;
        m_arm(e);
      end
      if (w == 4) m_arm(e);
    end
    m_settle(e);
  endtask

  // One full request/response with rsp_ready high; returns the acceptance edge.
  task automatic transact(input logic we, input logic [4:0] addr, input logic [31:0] wd,
                          input logic [3:0] st, input string tag, output longint acc);
    logic [31:0] erd;
    logic        eerr;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = st;
    rsp_ready = 1'b1;
    check({tag, ":req_ready"}, {31'h0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    acc = edge_n;
    m_apply(we, addr, wd, st, acc, erd, eerr);
    @(negedge clk);
    req_valid = 1'b0;
    m_settle(edge_n);
    check({tag, ":rsp_valid"}, {31'h0, rsp_valid}, 32'd1);
    check({tag, ":rsp_rdata"}, rsp_rdata, erd);
    check({tag, ":rsp_err"}, {31'h0, rsp_err}, {31'h0, eerr});
    check({tag, ":data_out"}, data_out, m_data);
    check({tag, ":wdt_tripped"}, {31'h0, wdt_tripped}, {31'h0, m_trip});
    @(posedge clk);
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    m_settle(edge_n);
    check({tag, ":data_out"}, data_out, m_data);
    check({tag, ":wdt_tripped"}, {31'h0, wdt_tripped}, {31'h0, m_trip});
  endtask

  initial begin
    longint      acc;
    longint      r;
    logic [31:0] erd;
    logic        eerr;
    logic [31:0] held;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wd;
    logic [3:0]  st;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 5'h00;
    req_wdata = 32'h0; req_wstrb = 4'h0; rsp_ready = 1'b1;
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset:data_out", data_out, SAFE);
    check("reset:req_ready", {31'h0, req_ready}, 32'd1);
    check("reset:rsp_valid", {31'h0, rsp_valid}, 32'd0);
    check("reset:rsp_rdata", rsp_rdata, 32'h0);
    check("reset:rsp_err", {31'h0, rsp_err}, 32'd0);
    check("reset:wdt_tripped", {31'h0, wdt_tripped}, 32'd0);

    transact(1'b0, 5'h00, 32'h0, 4'h0, "rd_safe", acc);

    // Byte-strobed write into a cleared DATA register.
    transact(1'b1, 5'h00, 32'h0000_0000, 4'hF, "clr_data", acc);
    transact(1'b1, 5'h00, 32'h1234_5678, 4'b0101, "strb_wr", acc);
    #1 check("strb_wr:value", data_out, 32'h0034_0078);

    transact(1'b1, 5'h00, 32'h0000_00F0, 4'hF, "base_f0", acc);
    transact(1'b1, 5'h04, 32'h0000_000F, 4'hF, "set", acc);
    #1 check("set:value", data_out, 32'h0000_00FF);
    transact(1'b1, 5'h08, 32'h0000_0081, 4'hF, "clr", acc);
    #1 check("clr:value", data_out, 32'h0000_007E);
    transact(1'b1, 5'h0C, 32'h0000_00FF, 4'hF, "tog", acc);
    #1 check("tog:value", data_out, 32'h0000_0081);

    // Backpressure: response held while a second request waits.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 5'h00; rsp_ready = 1'b0;
    @(posedge clk);
    #1 m_apply(1'b0, 5'h00, 32'h0, 4'h0, edge_n, erd, eerr);
    @(negedge clk);
    req_we = 1'b1; req_wdata = 32'h0000_00AA; req_wstrb = 4'hF;
    held = m_data;
    for (int i = 0; i < 5; i++) begin
      check("bp:req_ready", {31'h0, req_ready}, 32'd0);
      check("bp:rsp_valid", {31'h0, rsp_valid}, 32'd1);
      check("bp:rsp_rdata", rsp_rdata, erd);
      check("bp:data_out", data_out, held);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp:ready_after", {31'h0, req_ready}, 32'd1);
    check("bp:idle_valid", {31'h0, rsp_valid}, 32'd0);
    check("bp:not_applied", data_out, held);
    @(posedge clk);
    #1 m_apply(1'b1, 5'h00, 32'h0000_00AA, 4'hF, edge_n, erd, eerr);
    @(negedge clk);
    req_valid = 1'b0;
    check("bp2:rsp_valid", {31'h0, rsp_valid}, 32'd1);
    check("bp2:data_out", data_out, 32'h0000_00AA);
    @(posedge clk);

    transact(1'b0, 5'h18, 32'h0, 4'h0, "unmapped_rd", acc);
    transact(1'b1, 5'h1C, 32'hFFFF_FFFF, 4'hF, "unmapped_wr", acc);
    transact(1'b0, 5'h14, 32'h0, 4'h0, "status_rd", acc);
    transact(1'b1, 5'h10, 32'h0000_0000, 4'hF, "load_wr0", acc);
    transact(1'b0, 5'h10, 32'h0, 4'h0, "load_rd", acc);

    // Reset while a response is pending drops it.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 5'h00; req_wdata = 32'h5555_5555;
    req_wstrb = 4'hF; rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; rsp_ready = 1'b1;
    m_reset();
    check("midrst:rsp_valid", {31'h0, rsp_valid}, 32'd0);
    check("midrst:req_ready", {31'h0, req_ready}, 32'd1);
    check("midrst:data_out", data_out, SAFE);
    check("midrst:rsp_rdata", rsp_rdata, 32'h0);

`ifdef GPIO_OUT_WATCHDOG_EN
    transact(1'b1, 5'h10, 32'd10, 4'hF, "wdt_load10", acc);
    transact(1'b1, 5'h00, 32'h0000_FFFF, 4'hF, "wdt_refresh", r);
    for (int g = 0; g < 40 && edge_n < r + 9; g++) @(negedge clk);
    m_settle(edge_n);
    check("wdt:before_trip_data", data_out, 32'h0000_FFFF);
    check("wdt:before_trip_flag", {31'h0, wdt_tripped}, 32'd0);
    @(negedge clk);
    m_settle(edge_n);
    check("wdt:trip_data", data_out, SAFE);
    check("wdt:trip_flag", {31'h0, wdt_tripped}, 32'd1);
    transact(1'b0, 5'h14, 32'h0, 4'h0, "wdt_status", acc);
    transact(1'b1, 5'h00, 32'h0000_1234, 4'hF, "wdt_refresh2", r);
    for (int g = 0; g < 40 && edge_n < r + 8; g++) @(negedge clk);
    transact(1'b1, 5'h00, 32'h0000_4321, 4'hF, "wdt_race", acc);
    #1;
    check("wdt_race:flag", {31'h0, wdt_tripped}, 32'd0);
    check("wdt_race:data", data_out, 32'h0000_4321);
    transact(1'b1, 5'h10, 32'd0, 4'hF, "wdt_disable", acc);
`endif

    // Randomized traffic with idle gaps.
    for (int t = 0; t < 60; t++) begin
      addr = 5'($urandom_range(0, 31));
      we   = 1'($urandom_range(0, 1));
      wd   = $urandom;
      st   = 4'($urandom_range(0, 15));
      if (addr[4:2] == 3'd4 && we && $urandom_range(0, 1) == 1) begin
        wd = 32'($urandom_range(1, 8));
        st = 4'hF;
      end
      transact(we, addr, wd, st, "rand", acc);
      repeat ($urandom_range(0, 3)) idle_check("rand_idle");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_out_port.md
# gpio_out_port

Memory-mapped 32-bit output register port between the RISC-V core's data bus and the bit-split stage that fans the word out to Basys3 LEDs and PID control lines. The core writes through a valid/ready request channel and gets a one-cycle-latency response. Set, clear and toggle aliases give atomic bit updates. An optional refresh watchdog forces the outputs to a safe value if firmware stops updating them.

## Interface
- `SAFE_VALUE`, default 32'h0000_0000: value driven on `data_out` at reset and on watchdog trip.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_we` in 1: 1 means write, 0 means read.
- `req_addr` in 5: byte address. Bits [1:0] are ignored; [4:2] is the word index.
- `req_wdata` in 32: write data.
- `req_wstrb` in 4: byte enables.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer takes the response.
- `rsp_rdata` out 32: read data. It is 0 for writes.
- `rsp_err` out 1: the address was unmapped.
- `data_out` out 32: output word, fed to the split stage.
- `wdt_tripped` out 1: watchdog has fired.

## Operation
- Word map:
  - 0 DATA: RW.
  - 1 SET: W1S, reads 0.
  - 2 CLR: W1C, reads 0.
  - 3 TOG: W1T, reads 0.
  - 4 WDT_LOAD: RW.
  - 5 STATUS: RO. Bit0 is `wdt_tripped`.
  - 6–7 are unmapped: reads return 0, writes are ignored, and `rsp_err`=1.
- Byte mask M: each `req_wstrb` bit expanded to 8 bits.
  - DATA becomes (DATA & ~M) | (wdata & M).
  - SET: DATA | (wdata & M).
  - CLR: DATA & ~(wdata & M).
  - TOG: DATA ^ (wdata & M).
  - WDT_LOAD is byte-merged like DATA.
- `data_out` is the DATA register directly; there is no extra output stage.
- Two-state FSM:
  - IDLE: `req_ready`=1.
  - On `req_valid`, the request is accepted and any write is applied at that edge. Response fields are registered and the FSM moves to RESP.
  - RESP: `req_ready`=0 and `rsp_valid`=1. Response fields are held stable until `rsp_ready`, then the FSM returns to IDLE.
  - Maximum throughput is one request per 2 cycles.
- Reads return register values as of the acceptance edge, before any write in that edge takes effect.
- Reset values:
  - DATA=`SAFE_VALUE`, WDT_LOAD=0, counter=0.
  - `wdt_tripped`=0, FSM=IDLE.
  - `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
- Reset mid-transaction drops the pending response without error.

## Timing
- Write acceptance at edge N: `data_out` takes its new value at N, visible from cycle N+1. `rsp_valid` also rises at N+1.
- Read acceptance at edge N: `rsp_rdata` is valid at N+1.
- With `rsp_ready` held high, the response lasts exactly 1 cycle.
- Watchdog (when compiled in):
  - Any write to DATA, SET, CLR or TOG loads the counter with the new WDT_LOAD and clears `wdt_tripped`.
  - A write to WDT_LOAD also reloads the counter.
  - While nonzero, the counter decrements by 1 per cycle.
  - On the 1→0 transition with WDT_LOAD≠0, DATA becomes `SAFE_VALUE` and `wdt_tripped`=1 on the same edge.
  - WDT_LOAD=0 disables the watchdog: counter is held at 0 and it never trips.
  - A refresh write on the same edge as expiry: the write wins, the counter reloads, and there is no trip.
  - After a trip, the counter stays at 0 until the next refresh.
  - Timeout: `SAFE_VALUE` appears exactly WDT_LOAD cycles after the refresh edge.

## Configuration
- `GPIO_OUT_WATCHDOG_EN` defined: WDT_LOAD, the 32-bit down-counter and trip logic are present.
- `GPIO_OUT_WATCHDOG_EN` undefined: no counter is built. WDT_LOAD and STATUS read 0, writes to them are accepted and ignored with `rsp_err`=0, and `wdt_tripped` is tied to 0.

## Structure
- Shared package `gpio_out_pkg`:
  - word-index constants (`GPIO_DATA`..`GPIO_STATUS`);
  - FSM state enum;
  - strobe-to-mask function.
- One sub-module, `gpio_out_wdt`: the counter, reload and expiry pulse. It is instantiated only under the macro.

## Test plan
- Reset, then read DATA → `rsp_rdata`=`SAFE_VALUE`, `rsp_err`=0, `data_out`=`SAFE_VALUE`.
- Write DATA 0x1234_5678 with strb 4'b0101 after DATA=0 → `data_out`=0x0034_0078 one cycle later.
- From DATA=0x0000_00F0: SET 0x0F → 0xFF; CLR 0x81 → 0x7E; TOG 0xFF → 0x81. Each `rsp_rdata`=0.
- Hold `rsp_ready`=0 for 5 cycles with `req_valid` held high → `req_ready` stays 0, response stays stable, and the second request is accepted only after the response handshake.
- Read address 0x18 → `rsp_err`=1, `rsp_rdata`=0, `data_out` unchanged.
- With `GPIO_OUT_WATCHDOG_EN`:
  - WDT_LOAD=10, then write DATA=0xFFFF → `data_out`=`SAFE_VALUE` and `wdt_tripped`=1 exactly 10 cycles after the write edge.
  - A refresh write on cycle 10 → no trip.
